// File: rtl/seq_divider_64_pkg.sv
// Shared types and constants for the iterative 64-bit restoring divider.
// DIV_SIGNED_EN adds the operand/result negation states to the state enum.
package div_pkg;
    localparam int DIV_W    = 64;
    localparam int DIV_ITER = 64;
    localparam int CNT_W    = $clog2(DIV_ITER);

    // Quotient reported for a zero divisor.
    localparam logic [DIV_W-1:0] DIV_ZERO_Q = '1;

`ifdef DIV_SIGNED_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE,
        ST_NEG_A,
        ST_NEG_B,
        ST_NEG_Q,
        ST_NEG_R
    } div_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } div_state_t;
`endif
endpackage

// File: rtl/seq_divider_64_subtractor.sv
// Shared 64-bit subtractor: s = a - b, cout = 1 when no borrow occurs.
module Subtractor_64
    import div_pkg::*;
(
    input  logic [DIV_W-1:0] a,
    input  logic [DIV_W-1:0] b,
    output logic [DIV_W-1:0] s,
    output logic             cout
);
    logic [DIV_W-1:0] b_inv;

    for (genvar gi = 0; gi < DIV_W; gi++) begin : g_inv
        assign b_inv[gi] = ~b[gi];
    end

    assign {cout, s} = {1'b0, a} + {1'b0, b_inv} + {{DIV_W{1'b0}}, 1'b1};
endmodule

// File: rtl/seq_divider_64.sv
// Iterative 64-bit restoring divider, one trial subtraction per cycle on a single
// shared subtractor. Define DIV_SIGNED_EN for two's-complement operands.
module seq_divider_64
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] quotient,
    output logic [DIV_W-1:0] remainder,
    output logic             div_by_zero
);
    div_state_t       state_reg;
    logic [DIV_W-1:0] r_reg;
    logic [DIV_W-1:0] q_reg;
    logic [DIV_W-1:0] d_reg;
    logic [CNT_W-1:0] cnt_reg;
`ifdef DIV_SIGNED_EN
    logic             sign_a_reg;
    logic             sign_b_reg;
`endif

    logic [DIV_W-1:0] shifted;
    logic [DIV_W-1:0] sub_a;
    logic [DIV_W-1:0] sub_b;
    logic [DIV_W-1:0] sub_s;
    logic             sub_cout;
    logic             trial_ok;
    logic [DIV_W-1:0] step_r;
    logic [DIV_W-1:0] step_q;

    assign shifted = {r_reg[DIV_W-2:0], q_reg[DIV_W-1]};

    // The CALC trial is the default pairing; negation states feed 0 - x instead.
    always_comb begin
        sub_a = shifted;
        sub_b = d_reg;
`ifdef DIV_SIGNED_EN
        case (state_reg)
            ST_NEG_A, ST_NEG_Q: begin sub_a = '0; sub_b = q_reg; end
            ST_NEG_B:           begin sub_a = '0; sub_b = d_reg; end
            ST_NEG_R:           begin sub_a = '0; sub_b = r_reg; end
            default: ;
        endcase
`endif
    end

    Subtractor_64 u_sub (
        .a    (sub_a),
        .b    (sub_b),
        .s    (sub_s),
        .cout (sub_cout)
    );

    // r_reg[63] is the 65th bit of the shifted value: when set, it always exceeds D.
    assign trial_ok = r_reg[DIV_W-1] | sub_cout;
    assign step_r   = trial_ok ? sub_s : shifted;
    assign step_q   = {q_reg[DIV_W-2:0], trial_ok};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            r_reg       <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            cnt_reg     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            sign_a_reg  <= 1'b0;
            sign_b_reg  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        d_reg   <= divisor;
                        r_reg   <= '0;
                        q_reg   <= dividend;
                        cnt_reg <= '0;
                        if (divisor == '0) begin
                            state_reg   <= ST_DONE;
                            done        <= 1'b1;
                            quotient    <= DIV_ZERO_Q;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            busy <= 1'b1;
`ifdef DIV_SIGNED_EN
                            sign_a_reg <= dividend[DIV_W-1];
                            sign_b_reg <= divisor[DIV_W-1];
                            state_reg  <= ST_NEG_A;
`else
                            state_reg  <= ST_CALC;
`endif
                        end
                    end
                end
`ifdef DIV_SIGNED_EN
                ST_NEG_A: begin
                    if (sign_a_reg)
                        q_reg <= sub_s;
                    state_reg <= ST_NEG_B;
                end
                ST_NEG_B: begin
                    if (sign_b_reg)
                        d_reg <= sub_s;
                    state_reg <= ST_CALC;
                end
`endif
                ST_CALC: begin
                    r_reg   <= step_r;
                    q_reg   <= step_q;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(DIV_ITER - 1)) begin
`ifdef DIV_SIGNED_EN
                        state_reg <= ST_NEG_Q;
`else
                        state_reg   <= ST_DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= step_q;
                        remainder   <= step_r;
                        div_by_zero <= 1'b0;
`endif
                    end
                end
`ifdef DIV_SIGNED_EN
                ST_NEG_Q: begin
                    if (sign_a_reg ^ sign_b_reg)
                        q_reg <= sub_s;
                    state_reg <= ST_NEG_R;
                end
                ST_NEG_R: begin
                    state_reg   <= ST_DONE;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    quotient    <= q_reg;
                    remainder   <= sign_a_reg ? sub_s : r_reg;
                    div_by_zero <= 1'b0;
                end
`endif
                ST_DONE: begin
                    done      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider_64.sv
// Scoreboard bench for seq_divider_64: expectations are queued when start is driven
// and popped when done is observed. Build with DIV_SIGNED_EN to exercise the signed variant.
module tb_seq_divider_64;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        busy;
    logic        done;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        div_by_zero;

`ifdef DIV_SIGNED_EN
    localparam int LAT = 69;
`else
    localparam int LAT = 65;
`endif
    localparam int WAIT_LIMIT = 300;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    seq_divider_64 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = a;
        sb = b;
        e.dbz = 1'b0;
        e.lat = LAT;
        if (b == 64'd0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
`ifdef DIV_SIGNED_EN
            if (a == 64'h8000_0000_0000_0000 && b == '1) begin
                e.q = 64'h8000_0000_0000_0000;
                e.r = 64'd0;
            end else begin
                e.q = sa / sb;
                e.r = sa % sb;
            end
`else
            e.q = a / b;
            e.r = a % b;
`endif
        end
        return e;
    endfunction

    // Called at a falling edge; returns at the falling edge of cycle 1.
    task automatic drive_start(input logic [63:0] a, input logic [63:0] b, input bit push);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        if (push) sb_q.push_back(model(a, b));
        @(negedge clk);
        start    = 1'b0;
        dividend = ~a;
        divisor  = ~b;
    endtask

    task automatic wait_done(output int cyc, output bit busy_ok);
        cyc     = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < WAIT_LIMIT) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got busy=%b done=%b dbz=%b q=%h r=%h, want all 0",
                               busy, done, div_by_zero, quotient, remainder);
        end
        // Reset and start together: reset must win.
        start = 1'b1; dividend = 64'd100; divisor = 64'd7;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_wins_busy: got %b, want 0", busy);
        end
        begin
            bit seen = 1'b0;
            repeat (70) begin @(negedge clk); if (done === 1'b1) seen = 1'b1; end
            n_checks++;
            if (seen) begin n_fail++; $display("FAIL reset_wins_done: got done pulse, want none"); end
        end
        $display("reset: outputs idle after reset, start under reset dropped");
    endtask

    task automatic test_basic();
        logic [63:0] va[5] = '{64'd100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1000, 64'hDEAD_BEEF_0123_4567, 64'd5};
        logic [63:0] vb[5] = '{64'd7, 64'h8000_0000_0000_0001, 64'd1000, 64'h1234, 64'd9};
        exp_t e; int cyc; bit busy_ok;
        for (int i = 0; i < 5; i++) begin
            drive_start(va[i], vb[i], 1'b1);
            wait_done(cyc, busy_ok);
            e = sb_q.pop_front();
            n_checks++;
            if (cyc !== e.lat) begin n_fail++; $display("FAIL basic_latency[%0d]: got cycle %0d, want %0d", i, cyc, e.lat); end
            n_checks++;
            if (quotient !== e.q) begin n_fail++; $display("FAIL basic_quotient[%0d]: got %h, want %h", i, quotient, e.q); end
            n_checks++;
            if (remainder !== e.r) begin n_fail++; $display("FAIL basic_remainder[%0d]: got %h, want %h", i, remainder, e.r); end
            n_checks++;
            if (div_by_zero !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL basic_flags[%0d]: got dbz=%b busy=%b, want 0 0", i, div_by_zero, busy);
            end
            n_checks++;
            if (!busy_ok) begin n_fail++; $display("FAIL basic_busy[%0d]: busy dropped before done", i); end
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse[%0d]: got done=%b after pulse, want 0", i, done); end
            $display("op %h / %h -> q=%h r=%h at cycle %0d", va[i], vb[i], quotient, remainder, cyc);
        end
`ifndef DIV_SIGNED_EN
        n_checks++;
        if (e.q !== 64'd0 || model(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001).r !== 64'h7FFF_FFFF_FFFF_FFFE) begin
            n_fail++; $display("FAIL model_sanity: reference model disagrees with hand-computed values");
        end
`endif
    endtask

    task automatic test_div_zero();
        exp_t e; int cyc; bit busy_ok;
        drive_start(64'd1234, 64'd0, 1'b1);
        wait_done(cyc, busy_ok);
        e = sb_q.pop_front();
        n_checks++;
        if (cyc !== 1) begin n_fail++; $display("FAIL dz_latency: got cycle %0d, want 1", cyc); end
        n_checks++;
        if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b, want 1", div_by_zero); end
        n_checks++;
        if (quotient !== 64'hFFFF_FFFF_FFFF_FFFF || quotient !== e.q) begin
            n_fail++; $display("FAIL dz_quotient: got %h, want ffffffffffffffff", quotient);
        end
        n_checks++;
        if (remainder !== 64'd1234) begin n_fail++; $display("FAIL dz_remainder: got %0d, want 1234", remainder); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL dz_busy: got %b, want 0", busy); end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || div_by_zero !== 1'b1) begin
            n_fail++; $display("FAIL dz_hold: got done=%b dbz=%b, want 0 1", done, div_by_zero);
        end
        $display("op 1234 / 0 -> q=%h r=%0d dbz=%b", quotient, remainder, div_by_zero);
    endtask

    task automatic test_reset_mid_op();
        exp_t e; int cyc; bit busy_ok; bit seen;
        drive_start(64'd50, 64'd5, 1'b0);
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
            n_fail++; $display("FAIL midrst_clear: got busy=%b done=%b dbz=%b q=%h r=%h, want all 0",
                               busy, done, div_by_zero, quotient, remainder);
        end
        seen = 1'b0;
        repeat (80) begin @(negedge clk); if (done === 1'b1) seen = 1'b1; end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL midrst_no_done: got done pulse after abort, want none"); end
        drive_start(64'd9, 64'd3, 1'b1);
        wait_done(cyc, busy_ok);
        e = sb_q.pop_front();
        n_checks++;
        if (cyc !== e.lat || quotient !== 64'd3 || remainder !== 64'd0) begin
            n_fail++; $display("FAIL midrst_fresh: got q=%0d r=%0d cycle %0d, want q=3 r=0 cycle %0d",
                               quotient, remainder, cyc, e.lat);
        end
        @(negedge clk);
        $display("op 50 / 5 aborted by reset; op 9 / 3 -> q=%0d r=%0d", quotient, remainder);
    endtask

    task automatic test_ignored_start();
        exp_t e; int cyc; int first_cyc; int ndone;
        logic [63:0] q_seen; logic [63:0] r_seen;
        drive_start(64'd1000, 64'd33, 1'b1);
        repeat (9) @(negedge clk);
        dividend = 64'd5; divisor = 64'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 11; ndone = 0; first_cyc = 0; q_seen = '0; r_seen = '0;
        repeat (150) begin
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) begin first_cyc = cyc; q_seen = quotient; r_seen = remainder; end
            end
            @(negedge clk);
            cyc++;
        end
        e = sb_q.pop_front();
        n_checks++;
        if (ndone !== 1) begin n_fail++; $display("FAIL ign_done_count: got %0d done pulses, want 1", ndone); end
        n_checks++;
        if (first_cyc !== e.lat) begin n_fail++; $display("FAIL ign_latency: got cycle %0d, want %0d", first_cyc, e.lat); end
        n_checks++;
        if (q_seen !== e.q || r_seen !== e.r) begin
            n_fail++; $display("FAIL ign_result: got q=%0d r=%0d, want q=%0d r=%0d", q_seen, r_seen, e.q, e.r);
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_not_queued: got busy=%b, want 0", busy); end
        $display("op 1000 / 33 with stray start -> q=%0d r=%0d, %0d done pulse(s)", q_seen, r_seen, ndone);
    endtask

    task automatic test_back_to_back();
        exp_t e; int cyc; bit busy_ok;
        logic [63:0] a; logic [63:0] b;
        for (int i = 0; i < 6; i++) begin
            a = {$urandom, $urandom};
            b = (i % 2 == 0) ? {32'd0, $urandom} : {$urandom, $urandom};
            if (b == 64'd0) b = 64'd1;
            drive_start(a, b, 1'b1);
            wait_done(cyc, busy_ok);
            e = sb_q.pop_front();
            n_checks++;
            if (cyc !== e.lat || quotient !== e.q || remainder !== e.r || !busy_ok) begin
                n_fail++; $display("FAIL b2b[%0d]: got q=%h r=%h cycle %0d busy_ok=%b, want q=%h r=%h cycle %0d",
                                   i, quotient, remainder, cyc, busy_ok, e.q, e.r, e.lat);
            end
            @(negedge clk);
            $display("op %h / %h -> q=%h r=%h", a, b, quotient, remainder);
        end
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed();
        logic [63:0] va[2] = '{-64'sd7, 64'h8000_0000_0000_0000};
        logic [63:0] vb[2] = '{64'sd2, -64'sd1};
        logic [63:0] wq[2] = '{-64'sd3, 64'h8000_0000_0000_0000};
        logic [63:0] wr[2] = '{-64'sd1, 64'd0};
        exp_t e; int cyc; bit busy_ok;
        for (int i = 0; i < 2; i++) begin
            drive_start(va[i], vb[i], 1'b1);
            wait_done(cyc, busy_ok);
            e = sb_q.pop_front();
            n_checks++;
            if (cyc !== 69) begin n_fail++; $display("FAIL signed_latency[%0d]: got cycle %0d, want 69", i, cyc); end
            n_checks++;
            if (quotient !== wq[i] || quotient !== e.q) begin
                n_fail++; $display("FAIL signed_quotient[%0d]: got %h, want %h", i, quotient, wq[i]);
            end
            n_checks++;
            if (remainder !== wr[i] || remainder !== e.r) begin
                n_fail++; $display("FAIL signed_remainder[%0d]: got %h, want %h", i, remainder, wr[i]);
            end
            @(negedge clk);
            $display("signed op %h / %h -> q=%h r=%h", va[i], vb[i], quotient, remainder);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_reset_mid_op();
        test_ignored_start();
        test_back_to_back();
`ifdef DIV_SIGNED_EN
        test_signed();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_divider_64.md
# seq_divider_64

Iterative 64-bit restoring divider for the execute stage. It computes quotient and remainder by time-sharing a single `Subtractor_64` instance, using one trial subtraction per cycle. A start/busy/done handshake sequences the operation. The block sits beside the ALU and lets the pipeline stall on `busy` while a divide completes.

## Interface
- No parameters. Data width is fixed at 64.
- `clk`  in  1  Sole clock. All state updates on the rising edge.
- `rst`  in  1  Synchronous, active-high reset.
- `start`  in  1  Request. Sampled only in IDLE.
- `dividend`  in  64  Captured on the accepted `start`.
- `divisor`  in  64  Captured on the accepted `start`.
- `busy`  out  1  High from the cycle after accept until `done` is asserted.
- `done`  out  1  One-cycle pulse when the results are valid.
- `quotient`  out  64  Result. Held until the next accepted `start`.
- `remainder`  out  64  Result. Held until the next accepted `start`.
- `div_by_zero`  out  1  Set together with `done` when `divisor` is 0. Held with the results.

## Operation
- **States:** IDLE, CALC, DONE. The signed build adds NEG_A, NEG_B, NEG_Q and NEG_R.
- **IDLE:**
  - `start` = 1 captures the operands and clears the partial remainder R.
  - The quotient shift register Q is loaded with the dividend.
  - The iteration counter is cleared to 0.
  - Next state is CALC, or DONE if the divisor is 0.
- **CALC, one step per cycle:**
  - The shifted value is `{R[62:0], Q[63]}`.
  - The subtractor computes shifted minus D.
  - The trial succeeds when `R[63] | cout`. Here cout = 1 means no borrow. `R[63]` covers the 65th bit of the shifted value.
  - On success: R ← S and the new Q LSB is 1.
  - On failure: R ← shifted value and the new Q LSB is 0.
  - Q shifts left by 1 each step.
  - After the 64th step the next state is DONE (unsigned build) or NEG_Q (signed build).
- **DONE:**
  - `quotient` = Q and `remainder` = R are registered.
  - `done` = 1 for one cycle, `busy` = 0, then return to IDLE.
- **Divide by zero:**
  - CALC is skipped.
  - `quotient` = 64'hFFFF_FFFF_FFFF_FFFF, `remainder` = dividend, `div_by_zero` = 1.
- **Single datapath:** the subtractor's A/B inputs are muxed by state. No other arithmetic unit is permitted.
- **Ignored requests:** `start` while busy or in DONE is ignored and not queued.

## Timing
- **Reset values:** every output is 0, state is IDLE, and the counter is 0.
- **Unsigned latency:**
  - Accept at edge 0.
  - CALC occupies cycles 1–64.
  - `done` is high in cycle 65.
  - A new `start` is accepted at the earliest in cycle 66.
- **Divide-by-zero latency:** `done` is high in cycle 1.
- **Signed latency:** two extra input cycles and two extra output cycles, so `done` is high in cycle 69.
- **Reset mid-operation:**
  - Abort and return to IDLE in the next cycle.
  - No `done` pulse is produced.
  - Results are cleared to 0.
- **Reset and `start` in the same cycle:** reset wins.

## Configuration
- **`DIV_SIGNED_EN` defined:** operands are two's complement.
  - NEG_A computes 0 − dividend if it is negative. NEG_B does the same for the divisor. Both use the shared subtractor; if an operand is not negative its state passes through.
  - The magnitude division then runs in CALC.
  - NEG_Q negates Q if the operand signs differ.
  - NEG_R negates R if the dividend is negative.
  - Divide by zero behaves as in the unsigned build.
  - MIN / −1 gives `quotient` = 64'h8000_0000_0000_0000 and `remainder` = 0.
- **Undefined:** unsigned only. The NEG_* states and their muxing are absent.

## Structure
- **Package `div_pkg`:**
  - State enum.
  - `DIV_W` = 64.
  - `DIV_ITER` = 64.
  - The all-ones divide-by-zero quotient constant.
- **Sub-module:** exactly one `Subtractor_64` instance, with operand muxes in front of it. The FSM, counter and the R/Q registers live in `seq_divider_64`.

## Test plan
- 100 / 7 → `quotient` = 14, `remainder` = 2; `done` in cycle 65 only; `busy` high for cycles 1–64.
- 64'hFFFF_FFFF_FFFF_FFFF / 64'h8000_0000_0000_0001 → `quotient` = 1, `remainder` = 64'h7FFF_FFFF_FFFF_FFFE. This exercises the `R[63]` path.
- 1234 / 0 → `done` in cycle 1, `div_by_zero` = 1, `quotient` = all ones, `remainder` = 1234.
- Start 50 / 5, assert `rst` in cycle 30 → no `done`, outputs 0. A fresh 9 / 3 then gives `quotient` = 3, `remainder` = 0.
- `start` pulsed in cycle 10 of an operation → ignored; the first result is unchanged and only one `done` occurs.
- With `DIV_SIGNED_EN`:
  - −7 / 2 → `quotient` = −3, `remainder` = −1, `done` in cycle 69.
  - MIN / −1 → `quotient` = 64'h8000_0000_0000_0000, `remainder` = 0.
